dac_spi_writer: RTL

- Consumes the per-channel output stream (dv_in/chan_in/data_in) produced by the output filter stage.
- Converts each word into a saturated unsigned DAC code and serializes it to an external multi-channel SPI DAC as one write-and-update frame.
- Coalesces per channel: only the newest pending value per channel is sent.
- Channels are arbitrated lowest-index-first, one frame at a time.

---
 rtl/dac_spi_writer_if.sv | 39 +++
 rtl/dac_spi_writer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/dac_spi_writer_if.sv
// Bus bundle for dac_spi_writer: filter-stage word stream in, SPI DAC pins and status out.
// The ovr_cnt_out signal exists only when DAC_OVR_CNT_EN is defined.
interface dac_spi_writer_if #(
    parameter int W_CHAN = 5,
    parameter int W_DIN  = 64
);
    logic              dv_in;
    logic [W_CHAN-1:0] chan_in;
    logic [W_DIN-1:0]  data_in;
    logic              dac_sclk_out;
    logic              dac_cs_n_out;
    logic              dac_din_out;
    logic              busy_out;
    logic              done_out;
    logic [W_CHAN-1:0] done_chan_out;
`ifdef DAC_OVR_CNT_EN
    logic [15:0]       ovr_cnt_out;

    modport master (
        output dv_in, chan_in, data_in,
        input  dac_sclk_out, dac_cs_n_out, dac_din_out, busy_out, done_out, done_chan_out,
        input  ovr_cnt_out
    );
    modport slave (
        input  dv_in, chan_in, data_in,
        output dac_sclk_out, dac_cs_n_out, dac_din_out, busy_out, done_out, done_chan_out,
        output ovr_cnt_out
    );
`else
    modport master (
        output dv_in, chan_in, data_in,
        input  dac_sclk_out, dac_cs_n_out, dac_din_out, busy_out, done_out, done_chan_out
    );
    modport slave (
        input  dv_in, chan_in, data_in,
        output dac_sclk_out, dac_cs_n_out, dac_din_out, busy_out, done_out, done_chan_out
    );
`endif
endinterface

// File: rtl/dac_spi_writer.sv
// Per-channel coalescing SPI DAC writer: saturates signed words to DAC codes and sends one
// {cmd, chan, code} frame per pending channel, lowest index first. Optional: DAC_OVR_CNT_EN.
module dac_spi_writer #(
    parameter int         W_CHAN   = 5,
    parameter int         N_DAC    = 8,
    parameter int         W_DIN    = 64,
    parameter int         W_DAC    = 16,
    parameter int         HALF_PER = 2,
    parameter int         CS_GAP   = 2,
    parameter logic [3:0] CMD_WR   = 4'b0011
) (
    input logic              clk_in,
    input logic              rst_in,
    dac_spi_writer_if.slave  bus
);
    localparam int W_FRAME = 8 + W_DAC;
    localparam int W_IDX   = (N_DAC > 1) ? $clog2(N_DAC) : 1;
    localparam int W_PH    = $clog2(2 * HALF_PER + 1);
    localparam int W_BIT   = $clog2(W_FRAME + 1);
    localparam int W_GAP   = $clog2(CS_GAP + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        GAP   = 2'd3
    } state_t;

    // Negative clamps to zero; anything above the code range clamps to full scale.
    function automatic logic [W_DAC-1:0] sat_code(input logic [W_DIN-1:0] d);
        logic [W_DAC-1:0] c;
        if (d[W_DIN-1]) begin
            c = {W_DAC{1'b0}};
        end else if (|d[W_DIN-2:W_DAC]) begin
            c = {W_DAC{1'b1}};
        end else begin
            c = d[W_DAC-1:0];
        end
        return c;
    endfunction

    state_t             state_q, state_d;
    logic [N_DAC-1:0]   pend_q, pend_d;
    logic [W_DAC-1:0]   code_mem_q [N_DAC];
    logic [W_IDX-1:0]   sel_q, sel_d;
    logic [W_FRAME-1:0] shreg_q, shreg_d;
    logic [W_PH-1:0]    ph_q, ph_d;
    logic [W_BIT-1:0]   bit_q, bit_d;
    logic [W_GAP-1:0]   gap_q, gap_d;
    logic               sclk_q, sclk_d;
    logic               cs_n_q, cs_n_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [W_CHAN-1:0]  done_chan_q, done_chan_d;

    logic               wr_en;
    logic [W_IDX-1:0]   wr_idx;
    logic               load_clr;
    logic               pick_any;
    logic [W_IDX-1:0]   pick_idx;

    assign wr_en  = bus.dv_in && ({1'b0, bus.chan_in} < (W_CHAN + 1)'(N_DAC));
    assign wr_idx = bus.chan_in[W_IDX-1:0];

    // Lowest-index pending channel wins arbitration.
    always_comb begin
        pick_any = |pend_q;
        pick_idx = {W_IDX{1'b0}};
        for (int i = N_DAC - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                pick_idx = W_IDX'(i);
            end else begin
                pick_idx = pick_idx;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        shreg_d     = shreg_q;
        ph_d        = ph_q;
        bit_d       = bit_q;
        gap_d       = gap_q;
        sclk_d      = sclk_q;
        cs_n_d      = cs_n_q;
        done_d      = 1'b0;
        done_chan_d = done_chan_q;
        load_clr    = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    sel_d   = pick_idx;
                    state_d = LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                shreg_d  = {CMD_WR, 4'(sel_q), code_mem_q[sel_q]};
                load_clr = 1'b1;
                cs_n_d   = 1'b0;
                sclk_d   = 1'b0;
                ph_d     = {W_PH{1'b0}};
                bit_d    = {W_BIT{1'b0}};
                state_d  = SHIFT;
            end
            SHIFT: begin
                // Data only moves on the falling sclk edge, so it is stable around every rise.
                if (ph_q == W_PH'(2 * HALF_PER - 1)) begin
                    sclk_d = 1'b0;
                    ph_d   = {W_PH{1'b0}};
                    if (bit_q == W_BIT'(W_FRAME - 1)) begin
                        shreg_d     = {W_FRAME{1'b0}};
                        cs_n_d      = 1'b1;
                        done_d      = 1'b1;
                        done_chan_d = W_CHAN'(sel_q);
                        gap_d       = {W_GAP{1'b0}};
                        state_d     = GAP;
                    end else begin
                        shreg_d = {shreg_q[W_FRAME-2:0], 1'b0};
                        bit_d   = bit_q + W_BIT'(1);
                    end
                end else begin
                    ph_d = ph_q + W_PH'(1);
                    if (ph_q == W_PH'(HALF_PER - 1)) begin
                        sclk_d = 1'b1;
                    end else begin
                        sclk_d = sclk_q;
                    end
                end
            end
            GAP: begin
                if (gap_q == W_GAP'(CS_GAP - 1)) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + W_GAP'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // A write landing on the LOAD edge of the same channel re-arms it.
    always_comb begin
        pend_d = pend_q;
        if (load_clr) begin
            pend_d[sel_q] = 1'b0;
        end else begin
            pend_d = pend_q;
        end
        if (wr_en) begin
            pend_d[wr_idx] = 1'b1;
        end else begin
            pend_d = pend_d;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            pend_q      <= {N_DAC{1'b0}};
            sel_q       <= {W_IDX{1'b0}};
            shreg_q     <= {W_FRAME{1'b0}};
            ph_q        <= {W_PH{1'b0}};
            bit_q       <= {W_BIT{1'b0}};
            gap_q       <= {W_GAP{1'b0}};
            sclk_q      <= 1'b0;
            cs_n_q      <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            done_chan_q <= {W_CHAN{1'b0}};
            for (int i = 0; i < N_DAC; i++) begin
                code_mem_q[i] <= {W_DAC{1'b0}};
            end
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            sel_q       <= sel_d;
            shreg_q     <= shreg_d;
            ph_q        <= ph_d;
            bit_q       <= bit_d;
            gap_q       <= gap_d;
            sclk_q      <= sclk_d;
            cs_n_q      <= cs_n_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            done_chan_q <= done_chan_d;
            if (wr_en) begin
                code_mem_q[wr_idx] <= sat_code(bus.data_in);
            end
        end
    end

`ifdef DAC_OVR_CNT_EN
    logic [15:0] ovr_q, ovr_d;

    // Counts overwrites of a still-pending value; the LOAD-edge collision is not an overwrite.
    always_comb begin
        if (wr_en && pend_q[wr_idx] && !(load_clr && (sel_q == wr_idx)) && (ovr_q != 16'hFFFF)) begin
            ovr_d = ovr_q + 16'd1;
        end else begin
            ovr_d = ovr_q;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            ovr_q <= 16'd0;
        end else begin
            ovr_q <= ovr_d;
        end
    end

    assign bus.ovr_cnt_out = ovr_q;
`endif

    assign bus.dac_sclk_out  = sclk_q;
    assign bus.dac_cs_n_out  = cs_n_q;
    assign bus.dac_din_out   = shreg_q[W_FRAME-1];
    assign bus.busy_out      = busy_q;
    assign bus.done_out      = done_q;
    assign bus.done_chan_out = done_chan_q;
endmodule
